// File: rtl/codificador_display.sv
// Decodes an asynchronous active-low 7-segment + dp bus into a digit (0..7) or blank, with glitch filtering.
// Latency: a pattern captured at edge k and held steady is reported after edge k+1+STABLE_CYCLES.
// Backpressure: valid holds until ack; a new legal result while unacknowledged overwrites it and sets sticky overrun.
module codificador_display #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    input  logic       ack,
    output logic [2:0] num,
    output logic       blank,
    output logic       valid,
    output logic       erro,
    output logic       overrun
);

    localparam logic [0:0] ESPERA   = 1'b0;
    localparam logic [0:0] PENDENTE = 1'b1;

    // Counter saturation value and the counter value seen in the cycle before it reaches STABLE_CYCLES-1.
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] ACC_AT  = 4'(STABLE_CYCLES - 2);

    logic [7:0] seg_raw;
    logic [7:0] s1_q, seg_s_q, prev_q, last_rep_q, last_rep_d;
    logic [3:0] cnt_q, cnt_d;
    logic [0:0] state_q, state_d;
    logic [2:0] num_q, num_d;
    logic       blank_q, blank_d;
    logic       erro_q, erro_d;
    logic       over_q, over_d;

    logic       seg_chg;
    logic       accept;
    logic       legal;
    logic       is_blank;
    logic [2:0] dec_num;

    assign seg_raw = {dp, g, f, e, d, c, b, a};

    // Pattern table; bit 7 is dp, which must be off (1) for any legal pattern.
    always_comb begin
        legal    = 1'b1;
        is_blank = 1'b0;
        dec_num  = 3'd0;
        case (seg_s_q)
            8'b1_1000000: dec_num = 3'd0;
            8'b1_1111001: dec_num = 3'd1;
            8'b1_0100100: dec_num = 3'd2;
            8'b1_0110000: dec_num = 3'd3;
            8'b1_0011001: dec_num = 3'd4;
            8'b1_0010010: dec_num = 3'd5;
            8'b1_0000010: dec_num = 3'd6;
            8'b1_1111000: dec_num = 3'd7;
            8'b1_1111111: is_blank = 1'b1;
            default:      legal = 1'b0;
        endcase
    end

    // Stability tracking, acceptance and result/FSM next state.
    always_comb begin
        seg_chg    = (seg_s_q != prev_q);
        cnt_d      = seg_chg ? 4'd0 : ((cnt_q < CNT_MAX) ? cnt_q + 4'd1 : cnt_q);
        // Acceptance fires once per steady run, and only for a pattern different from the last one accepted.
        accept     = !seg_chg && (cnt_q == ACC_AT) && (seg_s_q != last_rep_q);
        last_rep_d = last_rep_q;
        state_d    = state_q;
        num_d      = num_q;
        blank_d    = blank_q;
        over_d     = over_q;
        erro_d     = 1'b0;
        if (accept) begin
            last_rep_d = seg_s_q;
            if (legal) begin
                num_d   = dec_num;
                blank_d = is_blank;
                state_d = PENDENTE;
                if (state_q == PENDENTE && !ack) begin
                    over_d = 1'b1;
                end
            end else begin
                erro_d = 1'b1;
            end
        end
        // A legal acceptance in the same cycle as ack keeps the new result pending.
        if (!(accept && legal) && state_q == PENDENTE && ack) begin
            state_d = ESPERA;
        end
    end

    // Synchronizer, stability counter and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 8'hFF;
            seg_s_q    <= 8'hFF;
            prev_q     <= 8'hFF;
            cnt_q      <= 4'd0;
            last_rep_q <= 8'hFF;
            state_q    <= ESPERA;
            num_q      <= 3'd0;
            blank_q    <= 1'b0;
            erro_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            s1_q       <= seg_raw;
            seg_s_q    <= s1_q;
            prev_q     <= seg_s_q;
            cnt_q      <= cnt_d;
            last_rep_q <= last_rep_d;
            state_q    <= state_d;
            num_q      <= num_d;
            blank_q    <= blank_d;
            erro_q     <= erro_d;
            over_q     <= over_d;
        end
    end

    assign num     = num_q;
    assign blank   = blank_q;
    assign valid   = (state_q == PENDENTE);
    assign erro    = erro_q;
    assign overrun = over_q;

endmodule
